// File: rtl/md_pkg.sv
// ============================================================================
// Module : md_pkg
// Brief  : Shared types and helpers for the iterative multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIN  = 2'b10
    } md_state_t;

    function automatic logic is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_cond_neg.sv
// ============================================================================
// Module : cond_neg
// Brief  : Combinational conditional two's-complement negate.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~x + W'(1)) : x;

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module : mult_div_unit
// Brief  : Radix-2 MIPS multiply/divide unit owning HI/LO; one bit per cycle.
//          Optional divide-by-zero flag output enabled by MD_DIVZERO_FLAG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import md_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  md_op_t       op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
`ifdef MD_DIVZERO_FLAG_EN
    ,
    output logic         divz
`endif
);

    localparam int CW = $clog2(N);

    md_state_t     r_state;
    md_op_t        r_op;
    logic [CW-1:0] r_cnt;
    logic [2*N-1:0] r_acc;
    logic [N-1:0]  r_opnd;
    logic [N-1:0]  r_a_raw;
    logic          r_neg_res;
    logic          r_neg_rem;
    logic          r_divz;

    logic [N-1:0]   w_abs_a;
    logic [N-1:0]   w_abs_b;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_quot;
    logic [N-1:0]   w_rem;
    logic [N:0]     w_sum;
    logic [N:0]     w_trial;
    logic [2*N-1:0] w_acc_next;

    cond_neg #(.W(N)) u_abs_a (
        .x(a), .neg(is_signed(op) & a[N-1]), .res(w_abs_a)
    );

    cond_neg #(.W(N)) u_abs_b (
        .x(b), .neg(is_signed(op) & b[N-1]), .res(w_abs_b)
    );

    cond_neg #(.W(2*N)) u_prod (
        .x(r_acc), .neg(r_neg_res), .res(w_prod)
    );

    cond_neg #(.W(N)) u_quot (
        .x(r_acc[N-1:0]), .neg(r_neg_res), .res(w_quot)
    );

    cond_neg #(.W(N)) u_rem (
        .x(r_acc[2*N-1:N]), .neg(r_neg_rem), .res(w_rem)
    );

    // Multiply: {partial, multiplier} shifts right, adding the multiplicand on
    // LSB=1. Divide: {remainder, dividend} shifts left; quotient bits fill in.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_trial    = r_acc[2*N-1:N-1] - {1'b0, r_opnd};
        w_acc_next = {w_sum, r_acc[N-1:1]};
        if (is_div(r_op)) begin
            if (!w_trial[N]) begin
                w_acc_next = {w_trial[N-1:0], r_acc[N-2:0], 1'b1};
            end else begin
                w_acc_next = {r_acc[2*N-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= MD_IDLE;
            r_op      <= MD_MULT;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_a_raw   <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_divz    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
`ifdef MD_DIVZERO_FLAG_EN
            divz      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MD_DIVZERO_FLAG_EN
            divz <= 1'b0;
`endif
            case (r_state)
                MD_IDLE: begin
                    if (start) begin
                        r_op      <= op;
                        r_neg_res <= is_signed(op) & (a[N-1] ^ b[N-1]);
                        r_neg_rem <= is_signed(op) & is_div(op) & a[N-1];
                        r_divz    <= is_div(op) & (b == '0);
                        r_a_raw   <= a;
                        r_opnd    <= is_div(op) ? w_abs_b : w_abs_a;
                        r_acc     <= {{N{1'b0}}, (is_div(op) ? w_abs_a : w_abs_b)};
                        r_cnt     <= CW'(N - 1);
                        busy      <= 1'b1;
                        r_state   <= MD_RUN;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                MD_RUN: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == '0) begin
                        r_state <= MD_FIN;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                MD_FIN: begin
                    if (!is_div(r_op)) begin
                        hi <= w_prod[2*N-1:N];
                        lo <= w_prod[N-1:0];
                    end else if (r_divz) begin
                        hi <= r_a_raw;
                        lo <= {N{1'b1}};
                    end else begin
                        hi <= w_rem;
                        lo <= w_quot;
                    end
`ifdef MD_DIVZERO_FLAG_EN
                    divz    <= r_divz;
`endif
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= MD_IDLE;
                end
                default: begin
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
